// File: rtl/branch_flag_unit.sv
// Digit-serial MSB-first comparator producing registered beq/blt flags with a
// fixed N-edge latency and a start/ready/valid handshake.
module branch_flag_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic             unsignedCmp,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             ready,
  output logic             valid,
  output logic             beq,
  output logic             blt
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               dec_q, dec_d, lt_q, lt_d, gt_q, gt_d;
  logic               valid_q, valid_d, beq_q, beq_d, blt_q, blt_d;
  logic [DIGIT-1:0]   chunk_a, chunk_b;

  assign chunk_a = a_q[WIDTH-1 -: DIGIT];
  assign chunk_b = b_q[WIDTH-1 -: DIGIT];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    dec_d   = dec_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    valid_d = 1'b0;
    beq_d   = beq_q;
    blt_d   = blt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d = opA;
          b_d = opB;
          // Flipping the sign bits maps signed order onto unsigned order.
          if (!unsignedCmp) begin
            a_d[WIDTH-1] = ~opA[WIDTH-1];
            b_d[WIDTH-1] = ~opB[WIDTH-1];
          end
          dec_d   = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          cnt_d   = CW'(N);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!dec_q) begin
          if (chunk_a < chunk_b) begin
            dec_d = 1'b1;
            lt_d  = 1'b1;
          end else if (chunk_a > chunk_b) begin
            dec_d = 1'b1;
            gt_d  = 1'b1;
          end
        end
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          beq_d   = ~(lt_d | gt_d);
          blt_d   = lt_d;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dec_q   <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      valid_q <= 1'b0;
      beq_q   <= 1'b0;
      blt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dec_q   <= dec_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      valid_q <= valid_d;
      beq_q   <= beq_d;
      blt_q   <= blt_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign valid = valid_q;
  assign beq   = beq_q;
  assign blt   = blt_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit: latency, handshake, signed/unsigned
// ordering, ignored restarts and mid-operation reset.
module tb_branch_flag_unit;

  logic        clk;
  logic        resetN;
  logic        start;
  logic        unsignedCmp;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        ready;
  logic        valid;
  logic        beq;
  logic        blt;

  int unsigned n_tests;
  int unsigned n_fail;

  branch_flag_unit #(
    .WIDTH(32),
    .DIGIT(4)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .start      (start),
    .unsignedCmp(unsignedCmp),
    .opA        (opA),
    .opB        (opB),
    .ready      (ready),
    .valid      (valid),
    .beq        (beq),
    .blt        (blt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int unsigned k;
    k = 0;
    while (ready !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (ready !== 1'b1) check({tag, "_ready_timeout"}, 32'(ready), 32'd1);
  endtask

  // One full comparison; samples at negedge j = after edge k+j (k = start edge).
  task automatic do_cmp(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic u, input logic exp_beq, input logic exp_blt);
    int lat;
    int ready_low;
    int vcount;
    wait_ready(tag);
    opA = a;
    opB = b;
    unsignedCmp = u;
    start = 1'b1;
    @(posedge clk);
    lat = -1;
    ready_low = 0;
    vcount = 0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid === 1'b1) begin
        vcount++;
        if (lat < 0) lat = j;
      end
      if (ready === 1'b1) break;
      ready_low++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_ready_low"}, 32'(ready_low), 32'd9);
    check({tag, "_valid_cnt"}, 32'(vcount), 32'd1);
    check({tag, "_valid_off"}, 32'(valid), 32'd0);
    check({tag, "_beq"}, 32'(beq), 32'(exp_beq));
    check({tag, "_blt"}, 32'(blt), 32'(exp_blt));
  endtask

  initial begin
    int lat;
    int vcount;
    n_tests = 0;
    n_fail = 0;
    resetN = 1'b0;
    start = 1'b0;
    unsignedCmp = 1'b0;
    opA = '0;
    opB = '0;
    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_beq", 32'(beq), 32'd0);
    check("rst_blt", 32'(blt), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    do_cmp("eq5",      32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 1'b0);
    do_cmp("m1_s",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    do_cmp("m1_u",     32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    do_cmp("min_s",    32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    do_cmp("min_u",    32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
    do_cmp("last_lt",  32'h1234_5670, 32'h1234_5671, 1'b0, 1'b0, 1'b1);
    do_cmp("last_gt",  32'h1234_5671, 32'h1234_5670, 1'b0, 1'b0, 1'b0);

    // Restart during BUSY must be ignored.
    wait_ready("busy_start");
    opA = 32'd3;
    opB = 32'd9;
    unsignedCmp = 1'b0;
    start = 1'b1;
    @(posedge clk);
    lat = -1;
    vcount = 0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j == 2) begin
        opA = 32'd20;
        start = 1'b1;
      end
      if (valid === 1'b1) begin
        vcount++;
        if (lat < 0) lat = j;
      end
    end
    check("busy_start_valid_cnt", 32'(vcount), 32'd1);
    check("busy_start_latency", 32'(lat), 32'd8);
    check("busy_start_ready", 32'(ready), 32'd1);
    check("busy_start_blt", 32'(blt), 32'd1);
    check("busy_start_beq", 32'(beq), 32'd0);
    repeat (5) @(negedge clk);
    check("hold_blt", 32'(blt), 32'd1);
    check("hold_beq", 32'(beq), 32'd0);
    check("hold_valid", 32'(valid), 32'd0);

    // Reset mid-operation abandons the comparison.
    wait_ready("mid_rst");
    opA = 32'd1;
    opB = 32'd2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    resetN = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_beq", 32'(beq), 32'd0);
    check("mid_rst_blt", 32'(blt), 32'd0);
    #5;
    resetN = 1'b1;
    vcount = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (valid === 1'b1) vcount++;
    end
    check("mid_rst_no_valid", 32'(vcount), 32'd0);
    check("mid_rst_blt_held", 32'(blt), 32'd0);
    do_cmp("eq7", 32'd7, 32'd7, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
